data_memory: RTL

- Global data memory model. Sits directly downstream of the data memory controller and serves its MAX_THREADS-wide read/write request channels.
- Each channel has its own handshake FSM with a fixed, parameterised access latency. All channels share a single word-addressed storage array.
- A testbench preload port initialises contents before a kernel runs.

---
 rtl/data_memory_pkg.sv | 21 ++
 rtl/data_mem_channel.sv | 105 ++++++++++
 rtl/data_memory.sv | 82 ++++++++
 3 files changed

// File: rtl/data_memory_pkg.sv
// Shared types for the data memory model.
// State encodings and counter sizing helpers.
package data_memory_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_BUSY = 3'd1,
    RD_RESP = 3'd2,
    WR_BUSY = 3'd3,
    WR_RESP = 3'd4,
    DRAIN   = 3'd5
  } chan_state_t;

  function automatic int cnt_width(
    input int rl,
    input int wl
  );
    return $clog2(rl > wl ? rl : wl) + 1;
  endfunction

endpackage

// File: rtl/data_mem_channel.sv
// One request channel: handshake FSM, latency counter and latches.
// Exposes a write bundle and a read address to the shared array.
module data_mem_channel
  import data_memory_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 16,
  parameter int RL = 2,
  parameter int WL = 2,
  parameter int CW = cnt_width(RL, WL)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          rd_req_rdy,
  input  logic [AW-1:0] rd_req_addr,
  input  logic          rd_req_val,
  input  logic          rd_resp_rdy,
  output logic [DW-1:0] rd_resp_data,
  output logic          rd_resp_val,
  output logic          wr_req_rdy,
  input  logic [AW-1:0] wr_req_addr,
  input  logic [DW-1:0] wr_req_data,
  input  logic          wr_req_val,
  output logic          wr_resp_val,
  output logic          arr_we,
  output logic [AW-1:0] arr_waddr,
  output logic [DW-1:0] arr_wdata,
  output logic [AW-1:0] arr_raddr,
  input  logic [DW-1:0] arr_rdata
);

  chan_state_t   state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;

  assign rd_req_rdy = (state == IDLE);
  assign wr_req_rdy = (state == IDLE);
  assign arr_raddr  = addr_q;
  assign arr_waddr  = addr_q;
  assign arr_wdata  = data_q;
  // Reset in the commit cycle drops the write.
  assign arr_we = (state == WR_BUSY) && (cnt == '0) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      rd_resp_data <= '0;
      rd_resp_val  <= 1'b0;
      wr_resp_val  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rd_req_val) begin
            addr_q <= rd_req_addr;
            cnt    <= CW'(RL - 1);
            state  <= RD_BUSY;
          end else if (wr_req_val) begin
            addr_q <= wr_req_addr;
            data_q <= wr_req_data;
            cnt    <= CW'(WL - 1);
            state  <= WR_BUSY;
          end
        end
        RD_BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rd_resp_data <= arr_rdata;
            rd_resp_val  <= 1'b1;
            state        <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (rd_resp_rdy) begin
            rd_resp_val <= 1'b0;
            state       <= DRAIN;
          end
        end
        WR_BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            wr_resp_val <= 1'b1;
            state       <= WR_RESP;
          end
        end
        WR_RESP: begin
          wr_resp_val <= 1'b0;
          state       <= DRAIN;
        end
        DRAIN: begin
          // Held requests must drop before re-arming.
          if (!rd_req_val && !wr_req_val)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/data_memory.sv
// Global data memory: shared array, write arbitration, preload,
// and MAX_THREADS independent request channels.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int MEM_DATA_WIDTH = 16,
  parameter int MAX_THREADS    = 4,
  parameter int READ_LATENCY   = 2,
  parameter int WRITE_LATENCY  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic [MAX_THREADS-1:0]    mem_read_req_rdy,
  input  logic [MEM_ADDR_WIDTH-1:0] mem_read_req_addr [MAX_THREADS],
  input  logic [MAX_THREADS-1:0]    mem_read_req_addr_val,
  input  logic [MAX_THREADS-1:0]    mem_read_resp_rdy,
  output logic [MEM_DATA_WIDTH-1:0] mem_read_resp_data [MAX_THREADS],
  output logic [MAX_THREADS-1:0]    mem_read_resp_data_val,
  output logic [MAX_THREADS-1:0]    mem_write_req_rdy,
  input  logic [MEM_ADDR_WIDTH-1:0] mem_write_req_addr [MAX_THREADS],
  input  logic [MEM_DATA_WIDTH-1:0] mem_write_req_data [MAX_THREADS],
  input  logic [MAX_THREADS-1:0]    mem_write_req_val,
  output logic [MAX_THREADS-1:0]    mem_write_resp_val,
  input  logic                      load_en,
  input  logic [MEM_ADDR_WIDTH-1:0] load_addr,
  input  logic [MEM_DATA_WIDTH-1:0] load_data
);

  localparam int AW    = MEM_ADDR_WIDTH;
  localparam int DW    = MEM_DATA_WIDTH;
  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];

  logic [MAX_THREADS-1:0] we;
  logic [AW-1:0]          waddr [MAX_THREADS];
  logic [DW-1:0]          wdata [MAX_THREADS];
  logic [AW-1:0]          raddr [MAX_THREADS];
  logic [DW-1:0]          rdata [MAX_THREADS];

  for (genvar g = 0; g < MAX_THREADS; g++) begin : g_chan
    assign rdata[g] = mem[raddr[g]];

    data_mem_channel #(
      .AW(AW),
      .DW(DW),
      .RL(READ_LATENCY),
      .WL(WRITE_LATENCY)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .rd_req_rdy  (mem_read_req_rdy[g]),
      .rd_req_addr (mem_read_req_addr[g]),
      .rd_req_val  (mem_read_req_addr_val[g]),
      .rd_resp_rdy (mem_read_resp_rdy[g]),
      .rd_resp_data(mem_read_resp_data[g]),
      .rd_resp_val (mem_read_resp_data_val[g]),
      .wr_req_rdy  (mem_write_req_rdy[g]),
      .wr_req_addr (mem_write_req_addr[g]),
      .wr_req_data (mem_write_req_data[g]),
      .wr_req_val  (mem_write_req_val[g]),
      .wr_resp_val (mem_write_resp_val[g]),
      .arr_we      (we[g]),
      .arr_waddr   (waddr[g]),
      .arr_wdata   (wdata[g]),
      .arr_raddr   (raddr[g]),
      .arr_rdata   (rdata[g])
    );
  end

  // Later writes win: highest channel, then preload on top.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_THREADS; i++) begin
      if (we[i])
        mem[waddr[i]] <= wdata[i];
    end
    if (load_en)
      mem[load_addr] <= load_data;
  end

endmodule
